// File: rtl/reaction_game_core.sv
// -----------------------------------------------------------------------------
// reaction_game_core
//
// Game engine of the reflex reaction game. It runs a per-second countdown and
// lights one pseudo-random target LED. It scores switch flips against that
// target: +1 for a flip of only the target switch, -1 for any other switch
// activity. The score saturates at 0 and at 63.
//
// Parameters
//   TICK_CYCLES  clk cycles per game second
//   GAME_SECS    initial countdown value (1..63)
//   LFSR_SEED    nonzero LFSR reset value
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   synchronous, active-high reset
//   start      in   1   raw start button, rising edge begins a game
//   sw         in  16   raw board switches (asynchronous to clk)
//   led        out 16   one-hot target while playing, all-on when done
//   timer_out  out  6   seconds remaining (binary)
//   score_out  out  6   current score (binary)
//   game_over  out  1   high while the game is finished
// -----------------------------------------------------------------------------
module reaction_game_core #(
  parameter int          TICK_CYCLES = 100_000_000,
  parameter int          GAME_SECS   = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [5:0]  timer_out,
  output logic [5:0]  score_out,
  output logic        game_over
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, nextState_s;

  logic [15:0]   swS1_r, swS2_r, swS3_r;
  logic          startS1_r, startS2_r, startS3_r;
  logic [15:0]   lfsr_r;
  logic          lfsrFb_s;

  logic [15:0]   swEdge_s;
  logic          startRise_s;

  logic [5:0]    timer_r, nextTimer_s;
  logic [5:0]    score_r, nextScore_s;
  logic [TW-1:0] tick_r, nextTick_s;
  logic [3:0]    target_r, nextTarget_s;
  logic [3:0]    movedTarget_s;
  logic          hit_s, miss_s;

  logic [15:0]   led_r, nextLed_s;
  logic [5:0]    timerOut_r, nextTimerOut_s;
  logic          gameOver_r, nextGameOver_s;

  assign lfsrFb_s    = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign swEdge_s    = swS2_r ^ swS3_r;
  assign startRise_s = startS2_r & ~startS3_r;

  // A hit is the target switch toggling alone; anything else that moves is a miss.
  assign hit_s  = (swEdge_s == (16'd1 << target_r));
  assign miss_s = (swEdge_s != 16'h0000) && !hit_s;

  // The new target must differ from the old one so the lit LED always moves.
  assign movedTarget_s = (lfsr_r[3:0] == target_r) ? (lfsr_r[3:0] + 4'd1) : lfsr_r[3:0];

  // Input synchronisers with history flop, and the free-running LFSR.
  always_ff @(posedge clk) begin
    if (rst) begin
      swS1_r    <= 16'h0000;
      swS2_r    <= 16'h0000;
      swS3_r    <= 16'h0000;
      startS1_r <= 1'b0;
      startS2_r <= 1'b0;
      startS3_r <= 1'b0;
      lfsr_r    <= LFSR_SEED;
    end else begin
      swS1_r    <= sw;
      swS2_r    <= swS1_r;
      swS3_r    <= swS2_r;
      startS1_r <= start;
      startS2_r <= startS1_r;
      startS3_r <= startS2_r;
      lfsr_r    <= {lfsr_r[14:0], lfsrFb_s};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Game datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r    <= 6'd0;
      score_r    <= 6'd0;
      tick_r     <= '0;
      target_r   <= 4'd0;
      led_r      <= 16'h0000;
      timerOut_r <= 6'd0;
      gameOver_r <= 1'b0;
    end else begin
      timer_r    <= nextTimer_s;
      score_r    <= nextScore_s;
      tick_r     <= nextTick_s;
      target_r   <= nextTarget_s;
      led_r      <= nextLed_s;
      timerOut_r <= nextTimerOut_s;
      gameOver_r <= nextGameOver_s;
    end
  end

  // Next-state, datapath updates, and next output values.
  always_comb begin
    nextState_s  = state_r;
    nextTimer_s  = timer_r;
    nextScore_s  = score_r;
    nextTick_s   = tick_r;
    nextTarget_s = target_r;

    case (state_r)
      IDLE, DONE: begin
        if (startRise_s) begin
          nextState_s  = PLAY;
          nextTimer_s  = 6'(GAME_SECS);
          nextScore_s  = 6'd0;
          nextTick_s   = '0;
          nextTarget_s = lfsr_r[3:0];
        end else begin
          nextState_s = state_r;
        end
      end

      PLAY: begin
        // Countdown: the decrement that reaches zero ends the game on this edge.
        if (tick_r == TICK_LAST) begin
          nextTick_s  = '0;
          nextTimer_s = timer_r - 6'd1;
          if (timer_r == 6'd1) begin
            nextState_s = DONE;
          end else begin
            nextState_s = PLAY;
          end
        end else begin
          nextTick_s = tick_r + TW'(1);
        end

        // Scoring still applies in the cycle the timer expires.
        if (hit_s) begin
          nextTarget_s = movedTarget_s;
          if (score_r != 6'd63) begin
            nextScore_s = score_r + 6'd1;
          end else begin
            nextScore_s = score_r;
          end
        end else if (miss_s) begin
          if (score_r != 6'd0) begin
            nextScore_s = score_r - 6'd1;
          end else begin
            nextScore_s = score_r;
          end
        end else begin
          nextScore_s = score_r;
        end
      end

      default: begin
        nextState_s = IDLE;
      end
    endcase

    // Outputs are computed from the next state so they are registered
    // without adding a cycle of latency.
    case (nextState_s)
      PLAY: begin
        nextLed_s      = 16'd1 << nextTarget_s;
        nextTimerOut_s = nextTimer_s;
        nextGameOver_s = 1'b0;
      end
      DONE: begin
        nextLed_s      = 16'hFFFF;
        nextTimerOut_s = 6'd0;
        nextGameOver_s = 1'b1;
      end
      default: begin
        nextLed_s      = 16'h0000;
        nextTimerOut_s = 6'd0;
        nextGameOver_s = 1'b0;
      end
    endcase
  end

  assign led       = led_r;
  assign timer_out = timerOut_r;
  assign score_out = score_r;
  assign game_over = gameOver_r;

endmodule

// File: tb/tb_reaction_game_core.sv
// -----------------------------------------------------------------------------
// tb_reaction_game_core
//
// Directed bench for reaction_game_core. dutA (10 cycles/s, 5 s game) covers
// reset, countdown, hit/miss, simultaneous events and ignored inputs. dutB
// (100 cycles/s, 5 s game) has time for 65 hits to show score saturation.
// A reference LFSR tracks the target choice. Inputs change on the falling
// edge and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_reaction_game_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        startA, startB;
  logic [15:0] swA, swB;
  logic [15:0] ledA, ledB;
  logic [5:0]  timerA, timerB, scoreA, scoreB;
  logic        overA, overB;

  int errCount = 0;
  int chkCount = 0;
  int cyc = 0;
  int entryCyc = 0;

  logic [15:0] mLfsr, mPrev;
  logic [3:0]  tgtA, tgtB, othA;
  logic [5:0]  expScoreB;

  always #5 clk = ~clk;

  reaction_game_core #(.TICK_CYCLES(10), .GAME_SECS(5), .LFSR_SEED(16'hACE1)) dutA (
    .clk(clk), .rst(rst), .start(startA), .sw(swA),
    .led(ledA), .timer_out(timerA), .score_out(scoreA), .game_over(overA)
  );

  reaction_game_core #(.TICK_CYCLES(100), .GAME_SECS(5), .LFSR_SEED(16'hACE1)) dutB (
    .clk(clk), .rst(rst), .start(startB), .sw(swB),
    .led(ledB), .timer_out(timerB), .score_out(scoreB), .game_over(overB)
  );

  // Cycle counter and reference LFSR; mPrev is the value the DUT used on the last edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mLfsr <= 16'hACE1;
      mPrev <= 16'h0000;
    end else begin
      mPrev <= mLfsr;
      mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] moveTarget(input logic [3:0] cand, input logic [3:0] cur);
    return (cand == cur) ? cand + 4'd1 : cand;
  endfunction

  // Advance to the falling edge k cycles after the PLAY entry edge.
  task automatic waitTo(input int k);
    while (cyc < entryCyc + k) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    swA    = 16'h0000;
    swB    = 16'h0000;
    repeat (3) @(negedge clk);

    checkEq("rstLed", ledA, 16'h0000);
    checkEq("rstTimer", timerA, 6'd0);
    checkEq("rstScore", scoreA, 6'd0);
    checkEq("rstOver", overA, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Game 1: start, score a hit, then reset in the middle of play.
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    repeat (2) @(negedge clk);
    tgtA = mPrev[3:0];
    checkEq("g1Timer", timerA, 6'd5);
    checkEq("g1Led", ledA, 16'd1 << tgtA);
    swA[tgtA] = ~swA[tgtA];
    repeat (3) @(negedge clk);
    checkEq("g1Hit", scoreA, 6'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkEq("midRstLed", ledA, 16'h0000);
    checkEq("midRstTimer", timerA, 6'd0);
    checkEq("midRstScore", scoreA, 6'd0);
    checkEq("midRstOver", overA, 1'b0);
    checkEq("midRstLfsr", dutA.lfsr_r, 16'hACE1);
    // The switch left up produces one edge in IDLE; let it drain.
    repeat (5) @(negedge clk);
    checkEq("idleScore", scoreA, 6'd0);
    checkEq("idleLed", ledA, 16'h0000);

    // Game 2: full countdown with scoring and ignored inputs.
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    repeat (2) @(negedge clk);
    entryCyc = cyc;
    tgtA = mPrev[3:0];
    checkEq("g2Timer", timerA, 6'd5);
    checkEq("g2Score", scoreA, 6'd0);
    checkEq("g2Led", ledA, 16'd1 << tgtA);
    checkEq("g2Over", overA, 1'b0);

    swA[tgtA] = ~swA[tgtA];
    waitTo(3);
    tgtA = moveTarget(mPrev[3:0], tgtA);
    checkEq("hit1Score", scoreA, 6'd1);
    checkEq("hit1Led", ledA, 16'd1 << tgtA);

    swA[tgtA] = ~swA[tgtA];
    waitTo(6);
    tgtA = moveTarget(mPrev[3:0], tgtA);
    checkEq("hit2Score", scoreA, 6'd2);
    checkEq("hit2Led", ledA, 16'd1 << tgtA);

    // Target plus another switch together is a miss; start in PLAY is ignored.
    othA = tgtA + 4'd1;
    swA[tgtA] = ~swA[tgtA];
    swA[othA] = ~swA[othA];
    startA = 1'b1;
    waitTo(7);
    startA = 1'b0;
    waitTo(9);
    checkEq("simulMiss", scoreA, 6'd1);
    checkEq("simulLed", ledA, 16'd1 << tgtA);

    swA[othA] = ~swA[othA];
    waitTo(10);
    checkEq("tick1Timer", timerA, 6'd4);
    waitTo(12);
    checkEq("miss2Score", scoreA, 6'd0);

    swA[othA] = ~swA[othA];
    waitTo(15);
    checkEq("missFloor", scoreA, 6'd0);
    checkEq("missFloorLed", ledA, 16'd1 << tgtA);

    waitTo(20);
    checkEq("tick2Timer", timerA, 6'd3);
    waitTo(30);
    checkEq("tick3Timer", timerA, 6'd2);
    waitTo(40);
    checkEq("tick4Timer", timerA, 6'd1);

    // Hit timed to land on the final tick edge.
    waitTo(47);
    swA[tgtA] = ~swA[tgtA];
    waitTo(49);
    checkEq("preEndTimer", timerA, 6'd1);
    checkEq("preEndOver", overA, 1'b0);
    checkEq("preEndScore", scoreA, 6'd0);
    waitTo(50);
    checkEq("endScore", scoreA, 6'd1);
    checkEq("endOver", overA, 1'b1);
    checkEq("endLed", ledA, 16'hFFFF);
    checkEq("endTimer", timerA, 6'd0);

    // Switch activity in DONE is ignored.
    swA[4'd3] = ~swA[4'd3];
    waitTo(53);
    checkEq("doneSwScore", scoreA, 6'd1);
    checkEq("doneSwOver", overA, 1'b1);

    // Start from DONE begins a fresh game.
    startA = 1'b1;
    waitTo(54);
    startA = 1'b0;
    waitTo(56);
    checkEq("restartTimer", timerA, 6'd5);
    checkEq("restartScore", scoreA, 6'd0);
    checkEq("restartOver", overA, 1'b0);
    checkEq("restartLed", ledA, 16'd1 << mPrev[3:0]);

    // dutB: 65 consecutive hits saturate the score at 63.
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    repeat (2) @(negedge clk);
    tgtB = mPrev[3:0];
    expScoreB = 6'd0;
    checkEq("bStartLed", ledB, 16'd1 << tgtB);
    for (int i = 0; i < 65; i++) begin
      swB[tgtB] = ~swB[tgtB];
      repeat (3) @(negedge clk);
      if (expScoreB != 6'd63) expScoreB = expScoreB + 6'd1;
      tgtB = moveTarget(mPrev[3:0], tgtB);
      checkEq("bHitScore", scoreB, expScoreB);
      checkEq("bHitLed", ledB, 16'd1 << tgtB);
    end
    checkEq("bSatScore", scoreB, 6'd63);
    checkEq("bStillPlaying", overB, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

endmodule

// File: doc/reaction_game_core.md
# reaction_game_core

Game engine of the reflex reaction game. It runs a per-second countdown and lights one pseudo-random target LED. It then scores the player's switch flips against that target. Its outputs are the 6-bit `timer_out` and `score_out` values consumed by the binary-to-BCD converters and 7-segment display driver, plus the 16-bit LED pattern sent to the board LEDs.

## Interface
- `TICK_CYCLES`, default 100_000_000: clk cycles per game second (1 s at 100 MHz).
- `GAME_SECS`, default 30: initial countdown value, legal range 1..63.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value, must be nonzero.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  raw start button; its rising edge begins a game.
- `sw`  in  16  raw board switches, asynchronous to `clk`.
- `led`  out  16  LED pattern: one-hot target while playing.
- `timer_out`  out  6  seconds remaining, binary.
- `score_out`  out  6  current score, binary.
- `game_over`  out  1  high while in DONE.

## Operation
- **Input synchronisation.**
  - `sw` and `start` each pass through 2 flops, then a third history flop.
  - `sw_edge = s2 ^ s3` (16 bits).
  - `start_rise = s2 & ~s3`.
- **LFSR.**
  - 16-bit Fibonacci LFSR, shifted left every cycle in all states.
  - Feedback bit = l[15]^l[13]^l[12]^l[10].
  - Candidate target index = l[3:0].
  - Reset value is `LFSR_SEED`.
- **FSM: IDLE, PLAY, DONE.**
- **IDLE.**
  - Outputs: `led`=0, `timer_out`=0, `score_out` holds, `game_over`=0.
  - On `start_rise`: go to PLAY. Load timer=`GAME_SECS`, score=0, tick counter=0, target=l[3:0].
- **PLAY.**
  - `led` = 1<<target.
  - The tick counter counts 0..`TICK_CYCLES`-1.
  - On wrap, timer decrements by 1.
  - When the decrement produces 0, go to DONE on the same edge.
- **Hit.**
  - Condition: `sw_edge` == 1<<target. Only the target switch toggled; either direction counts.
  - Score increments, saturating at 63.
  - New target = l[3:0]. If that equals the current target, use (l[3:0]+1) mod 16 instead, so the target always moves.
- **Miss.**
  - Condition: `sw_edge` ≠ 0 and not a hit. This includes the target switch toggling together with other switches.
  - Score decrements, saturating at 0.
  - Target is unchanged.
- **Tick and hit/miss in the same cycle.** Both are applied.
  - A hit or miss in the cycle the timer reaches 0 is still scored.
- **`start_rise` in PLAY** is ignored.
- **DONE.**
  - `led`=16'hFFFF, `timer_out`=0, `score_out` holds the final score, `game_over`=1.
  - Switch edges are ignored.
  - On `start_rise`: perform the same load as from IDLE and go to PLAY.
- **Reset.**
  - `rst` overrides everything, including mid-game.
  - Result: state IDLE, `led`=0, `timer_out`=0, `score_out`=0, `game_over`=0, tick counter=0, target=0, LFSR=`LFSR_SEED`.
  - All sync flops are cleared to 0.
  - A switch already up at reset produces one `sw_edge` after release. It is harmless in IDLE.

## Timing
- All outputs are registered.
- Latency from an input change to its effect is 3 rising edges:
  - An `sw` change stable before edge N shows as a `score_out`/`led` change after edge N+2.
  - A `start` rise stable before edge N enters PLAY after edge N+2.
- The first timer decrement occurs `TICK_CYCLES` cycles after entry to PLAY.
- A game lasts exactly `GAME_SECS`×`TICK_CYCLES` cycles, from the PLAY entry edge to the DONE entry edge.
- `timer_out` changes only on tick edges. `score_out` changes at most once per cycle.

## Test plan
- **Reset mid-game.** Use `TICK_CYCLES`=10, `GAME_SECS`=5. Assert `rst` for 1 cycle in PLAY → next cycle: IDLE, all outputs 0, LFSR=16'hACE1.
- **Start and countdown.** Pulse `start` → PLAY 3 edges later, `timer_out`=5. `timer_out` then reads 4,3,2,1 at 10-cycle intervals. DONE is reached 50 cycles after PLAY entry, with `game_over`=1 and `led`=16'hFFFF.
- **Hit.** In PLAY, toggle the switch at the lit LED → `score_out` 0→1 three edges later. `led` moves to a different one-hot bit. Repeat 63+2 hits → `score_out` saturates at 63.
- **Miss.** Toggle a non-target switch with score=2 → score 1. Toggle again → 0. Toggle a third time → stays 0, `led` unchanged.
- **Simultaneous events.** Toggle the target together with one other switch → counted as a miss. A hit landing on the final tick edge → score incremented and DONE entered on the same edge.
- **Ignored inputs.** `start` during PLAY → no reload. Switch toggles in DONE → score unchanged. `start` in DONE → new game with score=0 and `timer_out`=5.
